// File: rtl/cop0_status_ctrl_pkg.sv
// Shared COP0 definitions: the op encoding (selector) plus register indices, bit
// positions, reset values, the MTC0 write-mask table and FSM states (cop0_info).
package selector;
  typedef enum logic [2:0] {
    NONE = 3'd0,
    MTC0 = 3'd1,
    ERET = 3'd2,
    EI   = 3'd3,
    DI   = 3'd4,
    LL   = 3'd5,
    SC   = 3'd6,
    EXC  = 3'd7
  } cop0_op;
endpackage

package cop0_info;
  localparam logic [4:0] IDX_COUNT   = 5'd9;
  localparam logic [4:0] IDX_COMPARE = 5'd11;
  localparam logic [4:0] IDX_STATUS  = 5'd12;
  localparam logic [4:0] IDX_CAUSE   = 5'd13;
  localparam logic [4:0] IDX_EPC     = 5'd14;
  localparam logic [4:0] IDX_LLADDR  = 5'd17;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int CA_TI  = 30;

  localparam logic [31:0] STATUS_RST = 32'h0040_0004;
  localparam logic [31:0] CAUSE_RST  = 32'h0000_0000;

  // Status: IE/EXL/ERL/KSU, IM[7:0], BEV. Cause: software IP[1:0] only.
  localparam logic [31:0] WMASK [32] = '{
    9:       32'hFFFF_FFFF,
    11:      32'hFFFF_FFFF,
    12:      32'h0040_FF1F,
    13:      32'h0000_0300,
    14:      32'hFFFF_FFFF,
    17:      32'hFFFF_FFFF,
    default: 32'h0000_0000
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTER = 2'd1,
    DRAIN = 2'd2
  } exc_state_e;

  function automatic logic [31:0] wmerge(logic [31:0] old_v, logic [31:0] wr_v,
                                         logic [31:0] mask);
    return (old_v & ~mask) | (wr_v & mask);
  endfunction
endpackage

// File: rtl/cop0_status_ctrl_if.sv
// Pipeline <-> COP0 bus: commit-stage ops in, architectural state and control out.
interface cop0_status_ctrl_if;
  selector::cop0_op op;
  logic        op_valid;
  logic [4:0]  waddr;
  logic [31:0] rt;
  logic [31:0] mem_addr;
  logic [31:0] epc_in;
  logic [4:0]  exc_code;
  logic        flush_ack;
  logic [31:0] rdata;
  logic [31:0] status;
  logic [31:0] cause;
  logic [31:0] epc;
  logic        llbit;
  logic        int_req;
  logic        stall;

  modport master (
    output op, op_valid, waddr, rt, mem_addr, epc_in, exc_code, flush_ack,
    input  rdata, status, cause, epc, llbit, int_req, stall
  );

  modport slave (
    input  op, op_valid, waddr, rt, mem_addr, epc_in, exc_code, flush_ack,
    output rdata, status, cause, epc, llbit, int_req, stall
  );
endinterface

// File: rtl/cop0_status_ctrl_int_sync.sv
// Multi-flop synchronizer bank for the asynchronous hardware interrupt lines.
module cop0_int_sync #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);
  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= async_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign sync_o = stage_q[DEPTH-1];
endmodule

// File: rtl/cop0_status_ctrl.sv
// COP0 Status/Cause/EPC/LL control with exception-entry FSM.
// Optional Count/Compare timer is built when COP0_TIMER_EN is defined.
module cop0_status_ctrl
  import cop0_info::*;
  import selector::*;
#(
  parameter int NUM_HW_INT  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_HW_INT-1:0] hw_int,
  cop0_status_ctrl_if.slave     bus
);
  exc_state_e  state_q, state_d;
  logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
  logic [31:0] lladdr_q, lladdr_d, pend_epc_q, pend_epc_d;
  logic        llbit_q, llbit_d;
  logic [4:0]  pend_code_q, pend_code_d;
  logic [5:0]  ip_hw_q;
  logic [NUM_HW_INT-1:0] hw_sync;
  logic [7:0]  ip_all;
  logic [31:0] cause_vis, rd_raw, rdata;
  logic        op_fire, take_exc, int_req, take, mtc0_wr, timer_hit, compare_wr;

  cop0_int_sync #(.WIDTH(NUM_HW_INT), .DEPTH(SYNC_STAGES)) u_int_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_i (hw_int),
    .sync_o  (hw_sync)
  );

  function automatic logic [31:0] eff_wmask(logic [4:0] idx);
`ifdef COP0_TIMER_EN
    return WMASK[idx];
`else
    if (idx == IDX_COUNT || idx == IDX_COMPARE) return 32'h0;
    return WMASK[idx];
`endif
  endfunction

  // The timer shares IP7 with the top hardware line.
  assign ip_all    = {ip_hw_q | {cause_q[CA_TI], 5'b0}, cause_q[9:8]};
  assign cause_vis = {cause_q[31:16], ip_all, cause_q[7:0]};

  assign int_req  = (state_q == IDLE) && status_q[ST_IE] && !status_q[ST_EXL] &&
                    !status_q[ST_ERL] && ((ip_all & status_q[15:8]) != 8'h0);
  assign op_fire  = bus.op_valid && (state_q == IDLE);
  assign take_exc = op_fire && (bus.op == EXC);
  assign take     = take_exc || int_req;
  // Any op committing alongside an accepted exception is flushed with it.
  assign mtc0_wr  = op_fire && !take && (bus.op == MTC0);

`ifdef COP0_TIMER_EN
  logic [31:0] count_q, compare_q;
  logic        tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      compare_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      tick_q <= ~tick_q;
      if (mtc0_wr && bus.waddr == IDX_COUNT) count_q <= bus.rt;
      else if (tick_q)                       count_q <= count_q + 32'd1;
      if (compare_wr) compare_q <= bus.rt;
    end
  end

  assign timer_hit  = (count_q == compare_q);
  assign compare_wr = mtc0_wr && (bus.waddr == IDX_COMPARE);
`else
  assign timer_hit  = 1'b0;
  assign compare_wr = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    cause_d     = cause_q;
    epc_d       = epc_q;
    lladdr_d    = lladdr_q;
    llbit_d     = llbit_q;
    pend_code_d = pend_code_q;
    pend_epc_d  = pend_epc_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d     = ENTER;
          pend_code_d = take_exc ? bus.exc_code : 5'd0;
          pend_epc_d  = bus.epc_in;
        end else if (op_fire) begin
          case (bus.op)
            MTC0: begin
              case (bus.waddr)
                IDX_STATUS: status_d = wmerge(status_q, bus.rt, WMASK[IDX_STATUS]);
                IDX_CAUSE:  cause_d  = wmerge(cause_q, bus.rt, WMASK[IDX_CAUSE]);
                IDX_EPC:    epc_d    = wmerge(epc_q, bus.rt, WMASK[IDX_EPC]);
                IDX_LLADDR: lladdr_d = wmerge(lladdr_q, bus.rt, WMASK[IDX_LLADDR]);
                default: ;
              endcase
            end
            ERET: begin
              if (status_q[ST_ERL]) status_d[ST_ERL] = 1'b0;
              else                  status_d[ST_EXL] = 1'b0;
              llbit_d = 1'b0;
            end
            EI: status_d[ST_IE] = 1'b1;
            DI: status_d[ST_IE] = 1'b0;
            LL: begin
              lladdr_d = bus.mem_addr >> 4;
              llbit_d  = 1'b1;
            end
            SC: llbit_d = 1'b0;
            default: ;
          endcase
        end
      end
      ENTER: begin
        // A nested exception keeps the original return address.
        if (!status_q[ST_EXL]) epc_d = pend_epc_q;
        cause_d[6:2]     = pend_code_q;
        status_d[ST_EXL] = 1'b1;
        state_d          = DRAIN;
      end
      DRAIN: if (bus.flush_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (compare_wr)     cause_d[CA_TI] = 1'b0;
    else if (timer_hit) cause_d[CA_TI] = 1'b1;
  end

  always_comb begin
    rd_raw = '0;
    case (bus.waddr)
      IDX_STATUS:  rd_raw = status_q;
      IDX_CAUSE:   rd_raw = cause_vis;
      IDX_EPC:     rd_raw = epc_q;
      IDX_LLADDR:  rd_raw = lladdr_q;
`ifdef COP0_TIMER_EN
      IDX_COUNT:   rd_raw = count_q;
      IDX_COMPARE: rd_raw = compare_q;
`endif
      default:     rd_raw = '0;
    endcase
    rdata = rd_raw;
    if (mtc0_wr) rdata = wmerge(rd_raw, bus.rt, eff_wmask(bus.waddr));
    if (op_fire && !take && (bus.op == EI || bus.op == DI)) rdata = status_q;
    if (!rst_n) rdata = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      status_q    <= STATUS_RST;
      cause_q     <= CAUSE_RST;
      epc_q       <= '0;
      lladdr_q    <= '0;
      llbit_q     <= 1'b0;
      pend_code_q <= '0;
      pend_epc_q  <= '0;
      ip_hw_q     <= '0;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      cause_q     <= cause_d;
      epc_q       <= epc_d;
      lladdr_q    <= lladdr_d;
      llbit_q     <= llbit_d;
      pend_code_q <= pend_code_d;
      pend_epc_q  <= pend_epc_d;
      ip_hw_q     <= 6'(hw_sync);
    end
  end

  assign bus.rdata   = rdata;
  assign bus.status  = status_q;
  assign bus.cause   = cause_vis;
  assign bus.epc     = epc_q;
  assign bus.llbit   = llbit_q;
  assign bus.int_req = int_req;
  assign bus.stall   = (state_q != IDLE);
endmodule

// File: tb/tb_cop0_status_ctrl.sv
// Directed bench for cop0_status_ctrl: register writes, EI/DI, LL/ERET,
// interrupt and exception entry, reset in the middle of a drain.
module tb_cop0_status_ctrl;
  import selector::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] hw_int;
  int         checks = 0;
  int         errors = 0;

  cop0_status_ctrl_if bus ();

  cop0_status_ctrl #(.NUM_HW_INT(6), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .hw_int (hw_int),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout reached before end of sequence");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.op       = NONE;
    bus.op_valid = 1'b0;
  endtask

  task automatic issue(input cop0_op o, input logic [4:0] a, input logic [31:0] d);
    bus.op       = o;
    bus.op_valid = 1'b1;
    bus.waddr    = a;
    bus.rt       = d;
  endtask

  initial begin
    rst_n         = 1'b0;
    hw_int        = '0;
    bus.op        = NONE;
    bus.op_valid  = 1'b0;
    bus.waddr     = 5'd0;
    bus.rt        = '0;
    bus.mem_addr  = '0;
    bus.epc_in    = '0;
    bus.exc_code  = '0;
    bus.flush_ack = 1'b0;
    repeat (3) tick();
    chk("rst_status", bus.status, 32'h0040_0004);
    chk("rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_int_req", {31'b0, bus.int_req}, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rel_status", bus.status, 32'h0040_0004);
    chk("rel_cause", bus.cause, 32'h0);
    chk("rel_epc", bus.epc, 32'h0);
    chk("rel_stall", {31'b0, bus.stall}, 32'h0);
    chk("rel_rdata", bus.rdata, 32'h0);

    // Masked write with same-cycle forwarding
    issue(MTC0, 5'd12, 32'hFFFF_FFFF);
    #1;
    chk("mtc0_fwd", bus.rdata, 32'h0040_FF1F);
    chk("mtc0_not_yet", bus.status, 32'h0040_0004);
    tick();
    idle_bus();
    chk("mtc0_status", bus.status, 32'h0040_FF1F);

    // ERET clears ERL first, then EXL
    issue(ERET, 5'd0, 32'h0);
    tick();
    chk("eret_erl", bus.status, 32'h0040_FF1B);
    tick();
    idle_bus();
    chk("eret_exl", bus.status, 32'h0040_FF19);

    issue(MTC0, 5'd12, 32'h0);
    tick();
    chk("status_zero", bus.status, 32'h0);

    // EI/DI return the old Status in the same cycle
    issue(EI, 5'd0, 32'h0);
    #1;
    chk("ei_rdata", bus.rdata, 32'h0);
    tick();
    chk("ei_status", bus.status, 32'h1);
    issue(DI, 5'd0, 32'h0);
    #1;
    chk("di_rdata", bus.rdata, 32'h1);
    tick();
    chk("di_status", bus.status, 32'h0);

    issue(MTC0, 5'd12, 32'h0000_0401);
    tick();
    chk("status_ie_im2", bus.status, 32'h0000_0401);

    // Cause accepts only the software IP bits
    issue(MTC0, 5'd13, 32'hFFFF_FFFF);
    #1;
    chk("cause_fwd", bus.rdata, 32'h0000_0300);
    tick();
    chk("cause_sw", bus.cause, 32'h0000_0300);
    chk("sw_no_int", {31'b0, bus.int_req}, 32'h0);
    issue(MTC0, 5'd13, 32'h0);
    tick();
    chk("cause_clr", bus.cause, 32'h0);

    // LL then ERET
    issue(LL, 5'd17, 32'h0);
    bus.mem_addr = 32'h0000_1000;
    tick();
    idle_bus();
    bus.waddr = 5'd17;
    #1;
    chk("ll_bit_set", {31'b0, bus.llbit}, 32'h1);
    chk("ll_addr", bus.rdata, 32'h0000_0100);
    issue(ERET, 5'd17, 32'h0);
    tick();
    idle_bus();
    chk("eret_llbit", {31'b0, bus.llbit}, 32'h0);
    chk("eret_keep_addr", bus.rdata, 32'h0000_0100);
    chk("eret_status", bus.status, 32'h0000_0401);

    // Interrupt on hw_int[0]: int_req three edges later
    bus.epc_in = 32'h8000_0100;
    hw_int = 6'b000001;
    #1;
    chk("irq_c0", {31'b0, bus.int_req}, 32'h0);
    tick();
    chk("irq_c1", {31'b0, bus.int_req}, 32'h0);
    tick();
    chk("irq_c2", {31'b0, bus.int_req}, 32'h0);
    tick();
    chk("irq_c3", {31'b0, bus.int_req}, 32'h1);
    chk("irq_cause_ip2", bus.cause, 32'h0000_0400);
    issue(MTC0, 5'd14, 32'hDEAD_BEEF);
    tick();
    idle_bus();
    chk("enter_stall", {31'b0, bus.stall}, 32'h1);
    chk("enter_exl_late", bus.status, 32'h0000_0401);
    chk("enter_int_low", {31'b0, bus.int_req}, 32'h0);
    tick();
    chk("drain_status", bus.status, 32'h0000_0403);
    chk("drain_epc", bus.epc, 32'h8000_0100);
    chk("drain_cause", bus.cause, 32'h0000_0400);
    tick();
    tick();
    chk("drain_hold", {31'b0, bus.stall}, 32'h1);
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    chk("drain_done", {31'b0, bus.stall}, 32'h0);
    chk("exl_masks_int", {31'b0, bus.int_req}, 32'h0);

    // EXC code 5 while EXL=1, MTC0 during entry dropped
    bus.epc_in   = 32'h8000_0200;
    bus.exc_code = 5'd5;
    issue(EXC, 5'd0, 32'h0);
    tick();
    issue(MTC0, 5'd14, 32'h1234_5678);
    chk("exc_enter", {31'b0, bus.stall}, 32'h1);
    tick();
    chk("exc5_cause", bus.cause, 32'h0000_0414);
    chk("exc5_epc", bus.epc, 32'h8000_0100);
    chk("exc5_status", bus.status, 32'h0000_0403);
    bus.flush_ack = 1'b1;
    tick();
    bus.flush_ack = 1'b0;
    idle_bus();
    chk("exc5_epc_kept", bus.epc, 32'h8000_0100);

    // ERET re-arms the pending interrupt; EXC in the same cycle wins
    issue(ERET, 5'd0, 32'h0);
    tick();
    idle_bus();
    chk("rearm_status", bus.status, 32'h0000_0401);
    chk("rearm_int", {31'b0, bus.int_req}, 32'h1);
    bus.epc_in   = 32'h8000_0300;
    bus.exc_code = 5'd3;
    issue(EXC, 5'd0, 32'h0);
    tick();
    idle_bus();
    chk("both_exl_late", bus.status, 32'h0000_0401);
    tick();
    chk("both_cause", bus.cause, 32'h0000_040C);
    chk("both_epc", bus.epc, 32'h8000_0300);
    chk("both_stall", {31'b0, bus.stall}, 32'h1);

    // Reset in the middle of DRAIN
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("mid_rst_status", bus.status, 32'h0040_0004);
    chk("mid_rst_cause", bus.cause, 32'h0);
    chk("mid_rst_epc", bus.epc, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_stall", {31'b0, bus.stall}, 32'h0);
    chk("post_rst_int", {31'b0, bus.int_req}, 32'h0);
    hw_int = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cop0_status_ctrl.md
COP0_STATUS_CTRL -- requirements
Module: cop0_status_ctrl

Interface
REQ-001 SHALL have parameter NUM_HW_INT, default 6, meaning number of hardware interrupt lines (1..6).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on each interrupt line (>=1).
REQ-003 SHALL use one clock, clk; reset is asynchronous and active-low, rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 op  input  selector::cop0_op  NONE/MTC0/ERET/EI/DI/LL/SC/EXC.
REQ-007 op_valid  input  1  op qualifier, one commit per cycle.
REQ-008 waddr  input  5  COP0 register index for MTC0/MFC0.
REQ-009 rt, mem_addr, epc_in  input  32 each  MTC0 data, LL address, faulting PC.
REQ-010 exc_code  input  5  Cause.ExcCode for EXC.
REQ-011 hw_int  input  NUM_HW_INT  asynchronous interrupt lines.
REQ-012 flush_ack  input  1  pipeline flush complete.
REQ-013 rdata  output  32  MFC0 read of waddr; EI/DI old Status.
REQ-014 status, cause, epc  output  32 each  architectural registers.
REQ-015 llbit  output  1  load-linked flag.
REQ-016 int_req  output  1  interrupt taken request.
REQ-017 stall  output  1  pipeline hold during exception entry.

Function
REQ-018 SHALL write masked: reg <= (reg & ~cop0_info::WMASK[idx]) | (rt & WMASK[idx]) on MTC0, one cycle later visible.
REQ-019 ERET SHALL clear Status.ERL if set, else Status.EXL; SHALL clear llbit.
REQ-020 EI/DI SHALL set/clear Status.IE; rdata SHALL return Status before the update, same cycle.
REQ-021 LL SHALL capture mem_addr>>4 into LLAddr and set llbit; SC SHALL clear llbit.
REQ-022 MFC0 reads SHALL forward an MTC0 to the same index in the same cycle (write-through).
REQ-023 Each hw_int SHALL pass SYNC_STAGES flops; Cause.IP[2+i] = synced line, level-sensitive.
REQ-024 int_req SHALL assert when Status.IE=1, EXL=0, ERL=0 and (Cause.IP & Status.IM) != 0, in state IDLE only.
REQ-025 FSM states IDLE, ENTER, DRAIN.
REQ-026 IDLE->ENTER on op_valid&&op==EXC, or on int_req (ExcCode 0, EPC = epc_in).
REQ-027 ENTER (1 cycle): EPC<=epc_in only if EXL=0; Cause.ExcCode<=code; Status.EXL<=1; Cause.BD unchanged; -> DRAIN.
REQ-028 DRAIN: hold until flush_ack, then -> IDLE; stall=1 in ENTER and DRAIN.
REQ-029 Simultaneous EXC and int_req SHALL take EXC code; simultaneous MTC0 and EXC SHALL discard the MTC0.
REQ-030 op_valid in ENTER/DRAIN SHALL be ignored.
REQ-031 Latency: EXC op to EXL visible = 2 cycles; int line edge to int_req = SYNC_STAGES+1 cycles.

Reset
REQ-032 On rst_n low: Status = 32'h0040_0004 (BEV=1, ERL=1), Cause=0, EPC=0, LLAddr=0, llbit=0, sync flops=0, FSM=IDLE.
REQ-033 Outputs at reset: rdata=0, int_req=0, stall=0; reset mid-DRAIN SHALL return to IDLE without awaiting flush_ack.

Configuration
REQ-034 Macro COP0_TIMER_EN: when defined, Count (idx 9) increments every second cycle, Compare (idx 11) write clears Cause.TI; Count==Compare sets Cause.TI and IP7.
REQ-035 Without COP0_TIMER_EN: Count/Compare read 0, writes ignored, IP7 = 0.

Structure
REQ-036 Register indices, Status/Cause bit positions, reset values and WMASK table SHALL live in package cop0_info; cop0_op enum in package selector.
REQ-037 The interrupt synchronizer SHALL be sub-module cop0_int_sync (parameterised width and depth).

Verification
REQ-038 Reset release -> Status=0x00400004, stall=0, rdata=0.
REQ-039 MTC0 Status rt=0xFFFFFFFF -> only WMASK bits set; MFC0 same cycle returns forwarded value.
REQ-040 EI with Status=0x00000000 -> rdata=0x00000000, next cycle Status.IE=1.
REQ-041 Status IE=1,IM2=1,EXL=0; hw_int[0] rises -> int_req after 3 cycles, EXL=1, EPC=epc_in, stall until flush_ack.
REQ-042 EXC code 5 during EXL=1 -> EPC unchanged, ExcCode=5; simultaneous MTC0 dropped.
REQ-043 LL addr 0x1000 then ERET -> LLAddr=0x100, llbit 1 then 0.
